mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 134 +++++++++++++
 tb/tb_mem_access_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory stage: one load/store outstanding, fixed MEM_LAT access latency.
// Optional feature macro: MEM_ACCESS_CNT_EN adds saturating load/store counters.
module mem_access_unit #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_load_flag,
  input  logic              out_store_flag,
  input  logic [ADDR_W-1:0] out_1_mem_addr,
  input  logic [DATA_W-1:0] out_1_mem_data,
  output logic [DATA_W-1:0] load_data,
`ifdef MEM_ACCESS_CNT_EN
  output logic [15:0]       load_cnt,
  output logic [15:0]       store_cnt,
`endif
  output logic              mem_in_done,
  output logic              mem_busy,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_e              state_q;
  logic [3:0]          lat_cnt_q;
  logic                is_store_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   load_data_q;
  logic                done_q;
  logic                busy_q;
  logic                err_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic accept_d;
  logic both_d;

  assign accept_d = out_load_flag ^ out_store_flag;
  assign both_d   = out_load_flag & out_store_flag;

  // Request FSM, memory array and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      is_store_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      load_data_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept_d) begin
            is_store_q <= out_store_flag;
            addr_q     <= out_1_mem_addr;
            data_q     <= out_1_mem_data;
            lat_cnt_q  <= LAT_INIT;
            busy_q     <= 1'b1;
            state_q    <= BUSY;
          end else if (both_d) begin
            err_q <= 1'b1;
          end
        end
        BUSY: begin
          if (lat_cnt_q == 4'd0) begin
            if (is_store_q) begin
              mem_q[addr_q] <= data_q;
            end else begin
              load_data_q <= mem_q[addr_q];
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_data   = load_data_q;
  assign mem_in_done = done_q;
  assign mem_busy    = busy_q;
  assign mem_err     = err_q;

`ifdef MEM_ACCESS_CNT_EN
  logic [15:0] load_cnt_q;
  logic [15:0] store_cnt_q;
  logic        fin_d;

  assign fin_d = (state_q == BUSY) && (lat_cnt_q == 4'd0);

  // Saturating completion counters, bumped on the edge that raises done
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else if (fin_d) begin
      if (is_store_q && store_cnt_q != 16'hFFFF) begin
        store_cnt_q <= store_cnt_q + 16'd1;
      end
      if (!is_store_q && load_cnt_q != 16'hFFFF) begin
        load_cnt_q <= load_cnt_q + 16'd1;
      end
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit.
// Driver models memory at transaction level; monitor checks on every output event.
module tb_mem_access_unit;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_f;
  logic        st_f;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] load_data;
  logic        mem_in_done;
  logic        mem_busy;
  logic        mem_err;
`ifdef MEM_ACCESS_CNT_EN
  logic [15:0] load_cnt;
  logic [15:0] store_cnt;
  int          ref_lc = 0;
  int          ref_sc = 0;
`endif

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_W(5), .DATA_W(32), .DEPTH(32), .MEM_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .out_load_flag(ld_f),
    .out_store_flag(st_f),
    .out_1_mem_addr(addr),
    .out_1_mem_data(wdata),
    .load_data(load_data),
`ifdef MEM_ACCESS_CNT_EN
    .load_cnt(load_cnt),
    .store_cnt(store_cnt),
`endif
    .mem_in_done(mem_in_done),
    .mem_busy(mem_busy),
    .mem_err(mem_err)
  );

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [32];
  logic [31:0] ref_ld;
  int          cyc = 0;
  int          bz_from = 0;
  int          bz_to = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    ref_ld = '0;
    q.delete();
    bz_from = 0;
    bz_to = 0;
`ifdef MEM_ACCESS_CNT_EN
    ref_lc = 0;
    ref_sc = 0;
`endif
  endfunction

  // kind: 0 load, 1 store, 2 both flags (error)
  function automatic void model_accept(int kind, logic [4:0] a,
                                       logic [31:0] d, int acc);
    exp_t e;
    e.kind = kind;
    e.cyc  = (kind == 2) ? acc : acc + LAT;
    if (kind == 0) ref_ld = ref_mem[a];
    if (kind == 1) ref_mem[a] = d;
    e.data = ref_ld;
    q.push_back(e);
    if (kind != 2) begin
      bz_from = acc;
      bz_to   = acc + LAT;
    end
  endfunction

  // Monitor: busy window every cycle, scoreboard pop on done/err
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("busy", {31'd0, mem_busy},
          {31'd0, (cyc >= bz_from && cyc < bz_to)});
      if (mem_in_done || mem_err) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {30'd0, mem_err, mem_in_done}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("event_kind", {30'd0, mem_err, mem_in_done},
              (e.kind == 2) ? 32'd2 : 32'd1);
          chk("event_cycle", cyc, e.cyc);
          chk("load_data", load_data, e.data);
`ifdef MEM_ACCESS_CNT_EN
          if (e.kind == 0 && ref_lc < 65535) ref_lc++;
          if (e.kind == 1 && ref_sc < 65535) ref_sc++;
`endif
        end
      end
    end
  end

  task automatic idle(int n);
    ld_f = 1'b0;
    st_f = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    ld_f = 1'b0;
    st_f = 1'b0;
    @(posedge clk);
    #1 model_reset();
    @(negedge clk);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_outs", {29'd0, mem_in_done, mem_busy, mem_err}, 32'd0);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the done negedge (load/store)
  // or at the next IDLE negedge (error).
  task automatic do_req(int kind, logic [4:0] a, logic [31:0] d,
                        bit from_done);
    bit got;
    ld_f  = (kind != 1);
    st_f  = (kind != 0);
    addr  = a;
    wdata = d;
    if (from_done) @(posedge clk);
    @(posedge clk);
    #1 model_accept(kind, a, d, cyc);
    if (kind == 2) begin
      ld_f = 1'b0;
      st_f = 1'b0;
      @(negedge clk);
    end else begin
      ld_f  = 1'($urandom_range(0, 1));
      st_f  = 1'($urandom_range(0, 1));
      addr  = 5'($urandom);
      wdata = $urandom;
      got = 1'b0;
      for (int i = 0; i < LAT + 4; i++) begin
        @(negedge clk);
        if (mem_in_done) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) chk("done_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic abort_store(logic [4:0] a, logic [31:0] d);
    ld_f  = 1'b0;
    st_f  = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    bz_from = cyc;
    bz_to   = cyc + LAT;
    ld_f = 1'b0;
    st_f = 1'b0;
    @(negedge clk);
    do_reset();
    idle(LAT + 4);
  endtask

  initial begin
    int  kind;
    int  prev;
    bit  b2b;
    rst   = 1'b1;
    ld_f  = 1'b0;
    st_f  = 1'b0;
    addr  = '0;
    wdata = '0;
    @(negedge clk);
    do_reset();
    idle(1);
    do_req(0, 5'd5, 32'd0, 1'b0);
    idle(2);
    do_req(1, 5'd7, 32'hDEADBEEF, 1'b0);
    idle(1);
    do_req(0, 5'd7, 32'd0, 1'b0);
    idle(1);
    do_req(2, 5'd7, 32'h0BAD0BAD, 1'b0);
    idle(2);
    do_req(0, 5'd7, 32'd0, 1'b0);
    idle(1);
    abort_store(5'd31, 32'h1234);
    do_req(0, 5'd31, 32'd0, 1'b0);
    idle(1);
    do_req(1, 5'd0, 32'hCAFEF00D, 1'b0);
    do_req(0, 5'd31, 32'd0, 1'b1);
    idle(1);
    do_req(0, 5'd0, 32'd0, 1'b0);
    prev = 0;
    for (int n = 0; n < 250; n++) begin
      kind = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      b2b  = 1'($urandom_range(0, 1));
      if (!b2b || prev == 2) idle(int'($urandom_range(1, 3)));
      do_req(kind, 5'($urandom), $urandom, b2b && prev != 2);
      prev = kind;
    end
    idle(LAT + 4);
    chk("queue_drained", q.size(), 32'd0);
`ifdef MEM_ACCESS_CNT_EN
    chk("load_cnt", {16'd0, load_cnt}, ref_lc);
    chk("store_cnt", {16'd0, store_cnt}, ref_sc);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
